// File: rtl/seg_display_driver.sv
// seg_display_driver
//   Converts an unsigned binary value to decimal with a double-dabble shifter and drives both a
//   static 7-segment bus and a time-multiplexed 7-segment/digit-enable pair.
//
//   Ports
//     clk       : clock; all state changes on the rising edge
//     rst       : synchronous, active-high reset
//     bin_in    : binary value, captured when a load is accepted
//     load      : start a conversion (accepted only when idle)
//     blank_lz  : blank leading zero digits (applied live)
//     busy      : a conversion is in progress
//     done      : one-cycle pulse when the displayed value changes
//     overflow  : last converted value did not fit in NUM_DIGITS digits
//     seg_all   : static segments, digit k at [7k+6:7k], segment order {g,f,e,d,c,b,a}
//     seg_mux   : segments of the digit currently being scanned
//     dig_en    : one-hot enable of the digit currently being scanned
module seg_display_driver #(
    parameter int unsigned NUM_DIGITS = 3,
    parameter int unsigned BIN_WIDTH  = 10,
    parameter int unsigned SCAN_DIV   = 50000,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [BIN_WIDTH-1:0]      bin_in,
    input  logic                      load,
    input  logic                      blank_lz,
    output logic                      busy,
    output logic                      done,
    output logic                      overflow,
    output logic [7*NUM_DIGITS-1:0]   seg_all,
    output logic [6:0]                seg_mux,
    output logic [NUM_DIGITS-1:0]     dig_en
);

    localparam int unsigned BCD_W = 4 * (NUM_DIGITS + 1);
    localparam int unsigned DISP_W = 4 * NUM_DIGITS;
    localparam int unsigned SEG_W = 7 * NUM_DIGITS;
    localparam int unsigned CNT_W = $clog2(BIN_WIDTH);
    localparam int unsigned PRE_W = $clog2(SCAN_DIV);
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    typedef enum logic [1:0] {StIdle, StConvert, StUpdate} state_e;

    state_e               state_q;
    logic [BIN_WIDTH-1:0] bin_q;
    logic [BCD_W-1:0]     bcd_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 ovf_acc_q;
    logic [DISP_W-1:0]    disp_q;
    logic                 overflow_q;
    logic                 done_q;
    logic [PRE_W-1:0]     pre_q;
    logic [IDX_W-1:0]     scan_q;
    logic [SEG_W-1:0]     seg_all_q;
    logic [6:0]           seg_mux_q;
    logic [NUM_DIGITS-1:0] dig_en_q;

    // Active-high segment code for one BCD nibble; values above 9 show as 0.
    function automatic logic [6:0] seg_code(input logic [3:0] nib);
        logic [6:0] code;
        case (nib)
            4'd0:    code = 7'b0111111;
            4'd1:    code = 7'b0000110;
            4'd2:    code = 7'b1011011;
            4'd3:    code = 7'b1001111;
            4'd4:    code = 7'b1100110;
            4'd5:    code = 7'b1101101;
            4'd6:    code = 7'b1111101;
            4'd7:    code = 7'b0000111;
            4'd8:    code = 7'b1111111;
            4'd9:    code = 7'b1100111;
            default: code = 7'b0111111;
        endcase
        return code;
    endfunction

    // Encode all digits, blanking zeros above the most significant nonzero digit.
    function automatic logic [SEG_W-1:0] encode(input logic [DISP_W-1:0] d, input logic blank);
        logic [SEG_W-1:0] r;
        logic             seen_nz;
        logic [3:0]       nib;
        r       = '0;
        seen_nz = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            nib = d[4*k +: 4];
            if (nib != 4'd0) seen_nz = 1'b1;
            if (blank && !seen_nz && (k != 0)) r[7*k +: 7] = 7'b0000000;
            else                               r[7*k +: 7] = seg_code(nib);
        end
        return r;
    endfunction

    // Double-dabble step: add 3 to every nibble >= 5, then shift {bcd,bin} left.
    logic [BCD_W-1:0]           bcd_adj;
    logic [BCD_W+BIN_WIDTH:0]   shifted;
    logic                       shift_out;
    logic [BCD_W-1:0]           bcd_shift;
    logic [BIN_WIDTH-1:0]       bin_shift;

    always_comb begin
        bcd_adj = bcd_q;
        for (int n = 0; n < NUM_DIGITS + 1; n++) begin
            if (bcd_q[4*n +: 4] >= 4'd5) bcd_adj[4*n +: 4] = 4'(bcd_q[4*n +: 4] + 4'd3);
        end
        shifted   = {bcd_adj, bin_q, 1'b0};
        shift_out = shifted[BCD_W+BIN_WIDTH];
        bcd_shift = shifted[BCD_W+BIN_WIDTH-1 -: BCD_W];
        bin_shift = shifted[BIN_WIDTH-1:0];
    end

    // Overflow at end of conversion. The sticky term catches wide inputs whose high decimal
    // digits would otherwise be lost off the top of the accumulator.
    logic              low_bad;
    logic              ovf_now;
    logic [DISP_W-1:0] disp_upd;

    always_comb begin
        low_bad = 1'b0;
        for (int n = 0; n < NUM_DIGITS; n++) begin
            if (bcd_q[4*n +: 4] > 4'd9) low_bad = 1'b1;
        end
        ovf_now  = ovf_acc_q | (bcd_q[BCD_W-1 -: 4] != 4'd0) | low_bad;
        disp_upd = ovf_now ? {NUM_DIGITS{4'd9}} : bcd_q[DISP_W-1:0];
    end

    // Next display contents and scan position; outputs are registered from these so that
    // seg_mux always matches the seg_all slice selected by dig_en.
    logic [IDX_W-1:0]      scan_nxt;
    logic [DISP_W-1:0]     disp_nxt;
    logic [SEG_W-1:0]      seg_all_nxt;
    logic [6:0]            seg_mux_nxt;
    logic [NUM_DIGITS-1:0] dig_en_nxt;
    logic [SEG_W-1:0]      seg_rst;

    always_comb begin
        scan_nxt = scan_q;
        if (pre_q == PRE_W'(SCAN_DIV - 1)) begin
            scan_nxt = (scan_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : scan_q + 1'b1;
        end
        disp_nxt    = (state_q == StUpdate) ? disp_upd : disp_q;
        seg_all_nxt = {SEG_W{ACTIVE_LOW}} ^ encode(disp_nxt, blank_lz);
        seg_mux_nxt = seg_all_nxt[7*scan_nxt +: 7];
        dig_en_nxt  = {NUM_DIGITS{ACTIVE_LOW}} ^ (NUM_DIGITS'(1) << scan_nxt);
        seg_rst     = {SEG_W{ACTIVE_LOW}} ^ encode('0, blank_lz);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            bin_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ovf_acc_q  <= 1'b0;
            disp_q     <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
            pre_q      <= '0;
            scan_q     <= '0;
            seg_all_q  <= seg_rst;
            seg_mux_q  <= seg_rst[6:0];
            dig_en_q   <= {NUM_DIGITS{ACTIVE_LOW}} ^ NUM_DIGITS'(1);
        end else begin
            done_q    <= 1'b0;
            pre_q     <= (pre_q == PRE_W'(SCAN_DIV - 1)) ? '0 : pre_q + 1'b1;
            scan_q    <= scan_nxt;
            disp_q    <= disp_nxt;
            seg_all_q <= seg_all_nxt;
            seg_mux_q <= seg_mux_nxt;
            dig_en_q  <= dig_en_nxt;
            case (state_q)
                StIdle: begin
                    if (load) begin
                        bin_q     <= bin_in;
                        bcd_q     <= '0;
                        cnt_q     <= '0;
                        ovf_acc_q <= 1'b0;
                        state_q   <= StConvert;
                    end
                end
                StConvert: begin
                    bcd_q     <= bcd_shift;
                    bin_q     <= bin_shift;
                    ovf_acc_q <= ovf_acc_q | shift_out | (bcd_q[BCD_W-1 -: 4] != 4'd0);
                    cnt_q     <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(BIN_WIDTH - 1)) state_q <= StUpdate;
                end
                StUpdate: begin
                    overflow_q <= ovf_now;
                    done_q     <= 1'b1;
                    state_q    <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy     = (state_q != StIdle);
    assign done     = done_q;
    assign overflow = overflow_q;
    assign seg_all  = seg_all_q;
    assign seg_mux  = seg_mux_q;
    assign dig_en   = dig_en_q;

endmodule

// File: doc/seg_display_driver.md
SEG_DISPLAY_DRIVER -- requirements
Module: seg_display_driver

Interface
REQ-001 Parameter NUM_DIGITS, default 3: number of decimal digits displayed, legal range 1..8.
REQ-002 Parameter BIN_WIDTH, default 10: width of the binary input, legal range 4..27.
REQ-003 Parameter SCAN_DIV, default 50000: clk cycles per digit scan slot, minimum 2.
REQ-004 Parameter ACTIVE_LOW, default 1: 1 means segment and digit-enable outputs are active-low; 0 means active-high.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 bin_in  input  BIN_WIDTH  unsigned binary value to display; sampled only on an accepted load.
REQ-008 load  input  1  conversion request; accepted only in IDLE.
REQ-009 blank_lz  input  1  1 means leading zeros are blanked; sampled live, not latched.
REQ-010 busy  output  1  high in CONVERT and UPDATE.
REQ-011 done  output  1  one-cycle pulse when the display registers update.
REQ-012 overflow  output  1  last converted value exceeded 10^NUM_DIGITS-1.
REQ-013 seg_all  output  7*NUM_DIGITS  static segments; digit k occupies bits [7k+6:7k]; digit 0 is the ones digit.
REQ-014 seg_mux  output  7  segments of the currently scanned digit.
REQ-015 dig_en  output  NUM_DIGITS  one-hot digit select for the multiplexed display.

Function
REQ-016 The FSM SHALL have states IDLE, CONVERT and UPDATE, with transitions IDLE->CONVERT on load, CONVERT->UPDATE after BIN_WIDTH shift cycles, and UPDATE->IDLE unconditionally.
REQ-017 On an accepted load, bin_in SHALL be captured into a shift register, and a BCD accumulator of 4*(NUM_DIGITS+1) bits SHALL clear.
REQ-018 Each CONVERT cycle SHALL perform the same operation: first add 3 to every BCD nibble that is >=5, then shift {bcd,bin} left by 1 (double-dabble).
REQ-019 A load asserted while busy SHALL be ignored; it is not queued.
REQ-020 Latency: load is sampled high at edge N; the display registers and done update at edge N+BIN_WIDTH+1; busy falls at that same edge.
REQ-021 Overflow SHALL be flagged when any nibble above NUM_DIGITS-1 is nonzero, or any low nibble is >9.
REQ-022 On overflow, all display digits SHALL show 9 and overflow SHALL be 1; both hold until the next done.
REQ-023 Segment order SHALL be {g,f,e,d,c,b,a}.
REQ-024 Active-high codes, 0..9: 0111111, 0000110, 1011011, 1001111, 1100110, 1101101, 1111101, 0000111, 1111111, 1100111.
REQ-025 Blank code SHALL be 0000000; nibble values >9 SHALL encode as 0.
REQ-026 When ACTIVE_LOW=1, seg_all, seg_mux and dig_en SHALL be the bitwise inverse of their active-high values.
REQ-027 With blank_lz=1, every zero digit above the most significant nonzero digit SHALL be blanked.
REQ-028 Digit 0 SHALL never be blanked.
REQ-029 A free-running prescaler SHALL count 0..SCAN_DIV-1 and then wrap; the scan index SHALL advance on wrap, 0..NUM_DIGITS-1, and wrap to 0.
REQ-030 dig_en SHALL select the current scan index.
REQ-031 seg_mux SHALL equal the seg_all slice of the current scan index in the same cycle.
REQ-032 Scanning SHALL continue unaffected by conversion activity, and the display SHALL change only at done, so no partial values are ever shown.
REQ-033 seg_all, seg_mux and dig_en SHALL be registered outputs.

Reset
REQ-034 While rst=1 at a clock edge, the FSM SHALL go to IDLE, and busy, done and overflow SHALL be 0.
REQ-035 While rst=1 at a clock edge, the display value SHALL be 0, the prescaler 0 and the scan index 0.
REQ-036 After reset with ACTIVE_LOW=1 and blank_lz=0, every seg_all digit SHALL be 1000000.
REQ-037 After reset with ACTIVE_LOW=1, dig_en SHALL be ~(1<<0).
REQ-038 Reset asserted mid-CONVERT SHALL abort the conversion with no done pulse, and the display SHALL return to 0.

Verification
REQ-039 Defaults, ACTIVE_LOW=0, bin_in=742, load for 1 cycle -> done exactly 11 cycles later; digits 2/1/0 = 0000111/1100110/1011011; overflow=0.
REQ-040 Defaults, bin_in=1000, load -> overflow=1 and all three digits 1100111 (9).
REQ-041 bin_in=5, blank_lz=1, ACTIVE_LOW=0 -> digits 2 and 1 = 0000000, digit 0 = 1101101; with bin_in=0, digit 0 = 0111111.
REQ-042 SCAN_DIV=4 -> dig_en cycles 001,010,100,001 with 4 clk per slot; seg_mux tracks the matching slice every cycle.
REQ-043 Second load 3 cycles after the first -> ignored, with a single done pulse showing the first value.
REQ-044 rst pulsed 5 cycles into a conversion -> no done, busy=0 next cycle, display shows 0, and a new load converts correctly.
